dense_mult_ctrl: RTL and testbench

- Sequencer that feeds the N×N systolic multiplier dense_mult.
- Host loads matrices A and B element-by-element into internal buffers, then pulses start.
- The block drives the skewed diagonal wavefront onto the array's 2N-1 input lanes for N cycles, waits a fixed drain time for results to emerge, then pulses done.
- Sits directly in front of dense_mult; its lane outputs connect 1:1 to dense_mult's a/b input buses and valid bits.

---
 rtl/dense_mult_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dense_mult_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dense_mult_ctrl.sv
// rtl/dense_mult_ctrl.sv - operand buffer and skewed wavefront sequencer for the dense_mult systolic array
//
// Purpose: the host fills the A and B operand buffers element by element while
// the block is idle, then pulses start. The block then drives the diagonal
// wavefront onto the 2N-1 A and B lanes for N cycles, waits DRAIN_CYCLES, and
// pulses done.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   wr_en, wr_sel      element write strobe, 0 = A buffer / 1 = B buffer
//   wr_row, wr_col     element index
//   wr_data            element value
//   wr_err             one-cycle pulse: a write arrived while busy and was dropped
//   start              launch pulse (ignored while busy)
//   busy, done         run in progress / one-cycle completion pulse
//   a_in_bus, b_in_bus lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_bit_a_in/_b  lane valids, bit k = lane k
module dense_mult_ctrl #(
  parameter  int N            = 4,
  parameter  int DATA_WIDTH   = 8,
  parameter  int DRAIN_CYCLES = 10,
  localparam int IDX_W        = (N > 1) ? $clog2(N) : 1,
  localparam int LANES        = 2 * N - 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic                        wr_sel,
  input  logic [IDX_W-1:0]            wr_row,
  input  logic [IDX_W-1:0]            wr_col,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        wr_err,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [LANES*DATA_WIDTH-1:0] a_in_bus,
  output logic [LANES-1:0]            valid_bit_a_in,
  output logic [LANES*DATA_WIDTH-1:0] b_in_bus,
  output logic [LANES-1:0]            valid_bit_b_in
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] a_q [N][N];
  logic [DATA_WIDTH-1:0] a_d [N][N];
  logic [DATA_WIDTH-1:0] b_q [N][N];
  logic [DATA_WIDTH-1:0] b_d [N][N];

  logic [LANES*DATA_WIDTH-1:0] a_bus_q, a_bus_d;
  logic [LANES*DATA_WIDTH-1:0] b_bus_q, b_bus_d;
  logic [LANES-1:0]            valid_q;
  logic                        busy_q, done_q, wr_err_q;

  // Sequencer: t counts feed steps, cnt counts drain cycles.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          t_d     = '0;
        end
      end
      S_FEED: begin
        if (t_q == IDX_W'(N - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer next-state includes the write committing at this edge, so a write
  // coinciding with start is already visible in the first wavefront step.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_en && (state_q == S_IDLE)) begin
      if (wr_sel) begin
        b_d[wr_row][wr_col] = wr_data;
      end else begin
        a_d[wr_row][wr_col] = wr_data;
      end
    end
  end

  // Lane values are computed from the next state so the registered outputs
  // line up with the state they belong to. Lane k carries A[t][k-t] and
  // B[k-t][t] while k-t is a valid index.
  always_comb begin
    int off;
    off     = 0;
    a_bus_d = '0;
    b_bus_d = '0;
    if (state_d == S_FEED) begin
      for (int k = 0; k < LANES; k++) begin
        off = k - int'(t_d);
        if ((off >= 0) && (off < N)) begin
          a_bus_d[k*DATA_WIDTH +: DATA_WIDTH] = a_d[t_d][IDX_W'(off)];
          b_bus_d[k*DATA_WIDTH +: DATA_WIDTH] = b_d[IDX_W'(off)][t_d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      cnt_q    <= '0;
      a_bus_q  <= '0;
      b_bus_q  <= '0;
      valid_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_bus_q  <= a_bus_d;
      b_bus_q  <= b_bus_d;
      valid_q  <= {LANES{state_d == S_FEED}};
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      wr_err_q <= wr_en && (state_q != S_IDLE);
    end
  end

  assign a_in_bus       = a_bus_q;
  assign b_in_bus       = b_bus_q;
  assign valid_bit_a_in = valid_q;
  assign valid_bit_b_in = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign wr_err         = wr_err_q;

endmodule

// File: tb/tb_dense_mult_ctrl.sv
// tb/tb_dense_mult_ctrl.sv - self-checking bench for dense_mult_ctrl
module tb_dense_mult_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DRAIN = 10;
  localparam int IW    = 2;
  localparam int LANES = 2 * N - 1;
  localparam int BUSW  = LANES * DW;
  localparam int LAST  = N + DRAIN + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en, wr_sel, start;
  logic [IW-1:0]   wr_row, wr_col;
  logic [DW-1:0]   wr_data;
  logic            wr_err, busy, done;
  logic [BUSW-1:0] a_in_bus, b_in_bus;
  logic [LANES-1:0] valid_bit_a_in, valid_bit_b_in;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0]   ref_a [N][N];
  logic [DW-1:0]   ref_b [N][N];
  logic [BUSW-1:0] snap_a1, snap_b1, snap_a4, snap_b2;

  dense_mult_ctrl #(.N(N), .DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_err(wr_err), .start(start), .busy(busy), .done(done),
    .a_in_bus(a_in_bus), .valid_bit_a_in(valid_bit_a_in),
    .b_in_bus(b_in_bus), .valid_bit_b_in(valid_bit_b_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Element A[r][c] travels on lane r+c and is presented at step r;
  // element B[r][c] travels on lane r+c and is presented at step c.
  function automatic logic [BUSW-1:0] exp_a(input int t);
    logic [BUSW-1:0] v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (r == t) v[(r+c)*DW +: DW] = ref_a[r][c];
    return v;
  endfunction

  function automatic logic [BUSW-1:0] exp_b(input int t);
    logic [BUSW-1:0] v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (c == t) v[(r+c)*DW +: DW] = ref_b[r][c];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ref_a[r][c] = '0;
        ref_b[r][c] = '0;
      end
  endtask

  task automatic wr(input int sel, input int r, input int c, input int d);
    logic [31:0] rv, cv, dv;
    rv = r; cv = c; dv = d;
    wr_en = 1'b1; wr_sel = sel[0]; wr_row = rv[IW-1:0]; wr_col = cv[IW-1:0]; wr_data = dv[DW-1:0];
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (sel != 0) ref_b[r][c] = dv[DW-1:0];
    else          ref_a[r][c] = dv[DW-1:0];
  endtask

  // Pulses start (any wr_* set up by the caller commits on the same edge) and
  // checks every output for LAST+5 cycles. wr_at: cycle to attempt a B[1][0]
  // write while busy; start_at: cycle to pulse a stray start.
  task automatic run_check(input int wr_at, input int start_at);
    logic [BUSW-1:0] ea, eb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= LAST + 5; c++) begin
      ea = (c <= N) ? exp_a(c - 1) : '0;
      eb = (c <= N) ? exp_b(c - 1) : '0;
      check($sformatf("valid_a c%0d", c), valid_bit_a_in, (c <= N) ? {LANES{1'b1}} : '0);
      check($sformatf("valid_b c%0d", c), valid_bit_b_in, (c <= N) ? {LANES{1'b1}} : '0);
      check($sformatf("a_bus c%0d", c), a_in_bus, ea);
      check($sformatf("b_bus c%0d", c), b_in_bus, eb);
      check($sformatf("busy c%0d", c), busy, (c <= LAST) ? 1'b1 : 1'b0);
      check($sformatf("done c%0d", c), done, (c == LAST) ? 1'b1 : 1'b0);
      check($sformatf("wr_err c%0d", c), wr_err, (wr_at != 0 && c == wr_at + 1) ? 1'b1 : 1'b0);
      if (c == 1) begin snap_a1 = a_in_bus; snap_b1 = b_in_bus; end
      if (c == 2) snap_b2 = b_in_bus;
      if (c == 4) snap_a4 = a_in_bus;
      if (c == wr_at) begin
        wr_en = 1'b1; wr_sel = 1'b1; wr_row = 1; wr_col = 0; wr_data = 8'd7;
      end else begin
        wr_en = 1'b0;
      end
      start = (c == start_at);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("reset a_bus", a_in_bus, '0);
    check("reset b_bus", b_in_bus, '0);
    check("reset valid", {valid_bit_a_in, valid_bit_b_in}, '0);
    check("reset busy/done/err", {busy, done, wr_err}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A = 1..16 row-major, B = identity
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(0, r, c, r * N + c + 1);
        wr(1, r, c, (r == c) ? 1 : 0);
      end
    run_check(0, 0);
    check("plan a cycle1", snap_a1, {8'd0, 8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1});
    check("plan b cycle1", snap_b1, 56'h1);
    check("plan a cycle4", snap_a4, {8'd16, 8'd15, 8'd14, 8'd13, 8'd0, 8'd0, 8'd0});
    check("plan b cycle2", snap_b2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0});

    // Write while busy (dropped) and stray start during DRAIN (ignored)
    run_check(3, 8);
    run_check(0, 0);
    check("b lane1 t0 keeps old B[1][0]", snap_b1[DW +: DW], 8'd0);

    // Same-cycle write and start
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 0; wr_col = 0; wr_data = 8'd99;
    ref_a[0][0] = 8'd99;
    run_check(0, 0);
    check("co-write a lane0 t0", snap_a1[DW-1:0], 8'd99);

    // Random operands
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          wr(0, r, c, int'($urandom_range(0, 255)));
          wr(1, r, c, int'($urandom_range(0, 255)));
        end
      run_check(0, 0);
    end

    // Asynchronous reset in the middle of FEED at t=2
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre-reset a_bus t2", a_in_bus, exp_a(2));
    rst_n = 1'b0;
    #1;
    check("async rst a_bus", a_in_bus, '0);
    check("async rst b_bus", b_in_bus, '0);
    check("async rst valid", {valid_bit_a_in, valid_bit_b_in}, '0);
    check("async rst busy/done", {busy, done}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    repeat (3) begin
      @(posedge clk); #1;
      check("post-reset idle", {busy, done, valid_bit_a_in}, '0);
    end
    run_check(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
